frame_mem_checker: RTL and testbench
====================================

# frame_mem_checker

Parametrised, synthesizable frame comparator for the SIFT pipeline. It walks a DUT image memory (blur layers, DoG planes) in row-major order and compares every pixel of NCH channels against a golden pixel stream. It reports saturating per-channel mismatch counts, the first mismatch location and the maximum absolute error. It replaces file-based post-run dumps with an in-line, cycle-accurate check usable in RTL, gate and FPGA runs.

## Interface
Parameters:
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- PIX_W, 8, bits per pixel per channel
- NCH, 4, channels compared in parallel (e.g. the four blur layers)
- TOL, 0, allowed absolute difference; a difference greater than TOL is a mismatch
- CNT_W, 20, width of each mismatch counter
- ROW_W, $clog2(ROWS), row index width
- COL_W, $clog2(COLS), column index width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame check
- abort  in  1  single-cycle pulse; cancels a frame check
- ch_mask  in  NCH  per-channel enable, sampled on accepted start
- rd_en  out  1  memory read strobe
- rd_row  out  ROW_W  read row
- rd_col  out  COL_W  read column
- rd_data  in  NCH*PIX_W  memory data, channel c at [c*PIX_W +: PIX_W], valid exactly 1 cycle after rd_en
- gold_valid  in  1  golden pixel available
- gold_ready  out  1  golden pixel consumed when gold_valid && gold_ready
- gold_data  in  NCH*PIX_W  golden pixel, same packing as rd_data
- busy  out  1  check in progress
- done  out  1  frame completed; level signal
- err_cnt  out  NCH*CNT_W  per-channel mismatch count, saturating
- first_err_valid  out  1  at least one mismatch recorded
- first_err_row  out  ROW_W  row of the first mismatch
- first_err_col  out  COL_W  column of the first mismatch
- first_err_ch  out  $clog2(NCH) (min 1)  channel of the first mismatch
- max_abs_err  out  PIX_W  largest |dut-gold| over enabled channels

## Operation
- FSM states: IDLE, FETCH, LATCH, CMP, DONE.
- IDLE/DONE, start=1 and abort=0:
  - Clear err_cnt, first_err_*, max_abs_err and done.
  - Latch ch_mask; row=col=0; go to FETCH.
- FETCH: rd_en=1 with rd_row/rd_col = current position; go to LATCH.
- LATCH: register rd_data into pix_q; go to CMP.
- CMP: gold_ready=1.
  - If gold_valid=0, wait in CMP; pix_q is held.
  - If gold_valid=1, for each channel c with ch_mask[c]=1:
    - d = |pix_q[c] - gold[c]|, computed as unsigned PIX_W.
    - max_abs_err = max(max_abs_err, d). This update ignores TOL.
    - If d > TOL: increment err_cnt[c], saturating at 2^CNT_W-1.
  - If this pixel has any mismatch and first_err_valid=0, record row, col and the lowest mismatching c, and set first_err_valid.
  - Advance col. At COLS-1, wrap col to 0 and increment row. After (ROWS-1, COLS-1), go to DONE; otherwise go to FETCH.
- DONE: done=1, busy=0, results frozen until the next accepted start.
- Channels with ch_mask[c]=0 never count, never update max_abs_err and never set first_err.
- start while busy is ignored.
- abort from any non-IDLE state: go to IDLE next cycle, done=0, results frozen at their partial values. abort wins over start in the same cycle.

## Timing
- Reset values: state IDLE; rd_en, gold_ready, busy, done, first_err_valid = 0; rd_row, rd_col, err_cnt, first_err_*, max_abs_err = 0.
- busy=1 in FETCH, LATCH and CMP.
- rd_en is high exactly one cycle per pixel. Exactly one golden beat is consumed per pixel.
- Throughput is 3 cycles per pixel with gold_valid held high. Each stalled CMP cycle adds 1.
- With start sampled at edge 0 and no stalls, done is first high after edge 3*ROWS*COLS+1.
- Results update on the edge that consumes the golden beat, with no extra latency.
- gold_ready is never high outside CMP. A golden beat offered in other states is not consumed.
- An asynchronous reset mid-frame returns every output to its reset value immediately.

## Test plan
Use COLS=4, ROWS=3, NCH=4, PIX_W=8, CNT_W=4 unless stated.
- Identical data, ch_mask=4'hF: done after 37 cycles; err_cnt all 0; first_err_valid=0; max_abs_err=0; 12 rd_en pulses, 12 handshakes.
- Golden ch2 at (row1,col2) = dut+5, TOL=0: err_cnt[2]=1, others 0; first_err=(1,2,ch2); max_abs_err=5. Repeat with TOL=5: err_cnt[2]=0, max_abs_err=5.
- Errors on ch1 at (0,3) and ch0 and ch3 at (2,0), dut=0/gold=255 on ch3: first_err=(0,3,ch1); max_abs_err=255. Repeat with ch_mask=4'b1101: ch1 ignored, first_err=(2,0,ch0).
- Every pixel wrong on ch0 with CNT_W=3: err_cnt[0] saturates at 7 and does not wrap.
- gold_valid toggled 50% randomly: results equal the no-stall run; gold_ready is only high in CMP; done delayed by exactly the number of stalled cycles.
- abort at pixel 5, start and abort asserted together, start while busy, rst_n dropped mid-frame: go to IDLE with partial counts held and done=0; abort wins; the mid-frame start is ignored; reset clears all outputs asynchronously.

Source files
------------

// File: rtl/frame_mem_checker.sv
`default_nettype none
// frame_mem_checker -- in-line frame comparator for SIFT image memories (rev 1.0)
// Walks the DUT memory row-major and scores each pixel against a golden stream.
module frame_mem_checker #(
  parameter int COLS  = 640,
  parameter int ROWS  = 480,
  parameter int PIX_W = 8,
  parameter int NCH   = 4,
  parameter int TOL   = 0,
  parameter int CNT_W = 20,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [NCH-1:0]                           ch_mask,
  output logic                                     rd_en,
  output logic [ROW_W-1:0]                         rd_row,
  output logic [COL_W-1:0]                         rd_col,
  input  logic [NCH*PIX_W-1:0]                     rd_data,
  input  logic                                     gold_valid,
  output logic                                     gold_ready,
  input  logic [NCH*PIX_W-1:0]                     gold_data,
  output logic                                     busy,
  output logic                                     done,
  output logic [NCH*CNT_W-1:0]                     err_cnt,
  output logic                                     first_err_valid,
  output logic [ROW_W-1:0]                         first_err_row,
  output logic [COL_W-1:0]                         first_err_col,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_err_ch,
  output logic [PIX_W-1:0]                         max_abs_err
);

  localparam int          CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [31:0] TOL_U = 32'(TOL);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           r_state;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;
  logic [NCH-1:0]       r_mask;
  logic [NCH*PIX_W-1:0] r_pix;
  logic [CNT_W-1:0]     r_cnt [NCH];
  logic                 r_done;
  logic                 r_fev;
  logic [ROW_W-1:0]     r_frow;
  logic [COL_W-1:0]     r_fcol;
  logic [CH_W-1:0]      r_fch;
  logic [PIX_W-1:0]     r_max;

  logic [PIX_W-1:0]     w_diff [NCH];
  logic [NCH-1:0]       w_mis;
  logic                 w_any;
  logic [CH_W-1:0]      w_low;
  logic [PIX_W-1:0]     w_pmax;
  logic                 w_last_col;
  logic                 w_last_row;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [PIX_W-1:0] w_p;
    logic [PIX_W-1:0] w_g;
    assign w_p        = r_pix[g*PIX_W +: PIX_W];
    assign w_g        = gold_data[g*PIX_W +: PIX_W];
    assign w_diff[g]  = (w_p >= w_g) ? (w_p - w_g) : (w_g - w_p);
    assign w_mis[g]   = r_mask[g] && (32'(w_diff[g]) > TOL_U);
    assign err_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  // Walk downward so the lowest mismatching channel is the one that sticks.
  always_comb begin
    w_low  = '0;
    w_pmax = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_mis[c]) w_low = CH_W'(c);
      if (r_mask[c] && (w_diff[c] > w_pmax)) w_pmax = w_diff[c];
    end
  end

  assign w_any      = |w_mis;
  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_mask  <= '0;
      r_pix   <= '0;
      r_done  <= 1'b0;
      r_fev   <= 1'b0;
      r_frow  <= '0;
      r_fcol  <= '0;
      r_fch   <= '0;
      r_max   <= '0;
      for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            r_state <= S_FETCH;
            r_mask  <= ch_mask;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
            r_fev   <= 1'b0;
            r_frow  <= '0;
            r_fcol  <= '0;
            r_fch   <= '0;
            r_max   <= '0;
            for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
          end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_pix   <= rd_data;
          r_state <= S_CMP;
        end
        S_CMP: begin
          if (gold_valid) begin
            for (int c = 0; c < NCH; c++) begin
              if (w_mis[c] && (r_cnt[c] != {CNT_W{1'b1}})) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
            if (w_pmax > r_max) r_max <= w_pmax;
            if (w_any && !r_fev) begin
              r_fev  <= 1'b1;
              r_frow <= r_row;
              r_fcol <= r_col;
              r_fch  <= w_low;
            end
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_row   <= '0;
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + ROW_W'(1);
                r_state <= S_FETCH;
              end
            end else begin
              r_col   <= r_col + COL_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en           = (r_state == S_FETCH);
  assign rd_row          = r_row;
  assign rd_col          = r_col;
  assign gold_ready      = (r_state == S_CMP);
  assign busy            = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_CMP);
  assign done            = r_done;
  assign first_err_valid = r_fev;
  assign first_err_row   = r_frow;
  assign first_err_col   = r_fcol;
  assign first_err_ch    = r_fch;
  assign max_abs_err     = r_max;

endmodule
`default_nettype wire

// File: tb/tb_frame_mem_checker.sv
`default_nettype none
// tb_frame_mem_checker -- scoreboard bench; two instances (TOL=0/CNT_W=4 and
// TOL=5/CNT_W=3) share one stimulus and are scored against a frame-level model.
module tb_frame_mem_checker;
  localparam int COLS = 4, ROWS = 3, NPIX = 12;

  typedef struct packed {
    logic [3:0][7:0] cnt;
    logic            fev;
    logic [1:0]      frow;
    logic [1:0]      fcol;
    logic [1:0]      fch;
    logic [7:0]      mx;
    logic            done;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic [31:0] rd_data = '0, gold_data = '0;
  logic        gold_valid = 1'b0;

  logic rd_en0, rd_en1, gold_ready0, gold_ready1, busy0, busy1, done0, done1, fev0, fev1;
  logic [1:0]  rd_row0, rd_col0, rd_row1, rd_col1;
  logic [1:0]  frow0, fcol0, fch0, frow1, fcol1, fch1;
  logic [15:0] err_cnt0;
  logic [11:0] err_cnt1;
  logic [7:0]  mx0, mx1;

  frame_mem_checker #(.COLS(COLS), .ROWS(ROWS), .PIX_W(8), .NCH(4), .TOL(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .rd_en(rd_en0), .rd_row(rd_row0), .rd_col(rd_col0), .rd_data(rd_data),
    .gold_valid(gold_valid), .gold_ready(gold_ready0), .gold_data(gold_data),
    .busy(busy0), .done(done0), .err_cnt(err_cnt0), .first_err_valid(fev0),
    .first_err_row(frow0), .first_err_col(fcol0), .first_err_ch(fch0), .max_abs_err(mx0));

  frame_mem_checker #(.COLS(COLS), .ROWS(ROWS), .PIX_W(8), .NCH(4), .TOL(5), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1), .rd_data(rd_data),
    .gold_valid(gold_valid), .gold_ready(gold_ready1), .gold_data(gold_data),
    .busy(busy1), .done(done1), .err_cnt(err_cnt1), .first_err_valid(fev1),
    .first_err_row(frow1), .first_err_col(fcol1), .first_err_ch(fch1), .max_abs_err(mx1));

  always #5 clk = ~clk;

  logic [31:0] mem [NPIX];
  logic [31:0] gld [NPIX];
  res_t q0[$], q1[$];
  res_t last0, last1;
  int n_cmp = 0, n_fail = 0, cyc = 0;

  int k, since, n_rd, n_hs, stalls, prot_err;
  bit pend, last_hs, exp_ready, run_en = 1'b0, stall_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en0) rd_data <= mem[int'(rd_row0) * COLS + int'(rd_col0)];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: plain per-pixel scoring over row-major order.
  function automatic res_t model(input logic [3:0] mask, input int tol, input int cmax,
                                 input int npix, input bit dn);
    res_t r;
    int cnt [4];
    int mx;
    r = '0;
    mx = 0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int p = 0; p < npix; p++) begin
      int low;
      low = -1;
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          int a, b, d;
          a = int'(mem[p][8*c +: 8]);
          b = int'(gld[p][8*c +: 8]);
          d = (a > b) ? a - b : b - a;
          if (d > mx) mx = d;
          if (d > tol) begin
            if (cnt[c] < cmax) cnt[c]++;
            if (low < 0) low = c;
          end
        end
      end
      if (low >= 0 && !r.fev) begin
        r.fev  = 1'b1;
        r.frow = 2'(p / COLS);
        r.fcol = 2'(p % COLS);
        r.fch  = 2'(low);
      end
    end
    for (int c = 0; c < 4; c++) r.cnt[c] = 8'(cnt[c]);
    r.mx   = 8'(mx);
    r.done = dn;
    return r;
  endfunction

  function automatic logic [15:0] pack0(input res_t e);
    logic [15:0] v;
    for (int c = 0; c < 4; c++) v[c*4 +: 4] = e.cnt[c][3:0];
    return v;
  endfunction

  task automatic push_exp(input logic [3:0] mask, input int npix, input bit dn);
    last0 = model(mask, 0, 15, npix, dn);
    last1 = model(mask, 5, 7, npix, dn);
    q0.push_back(last0);
    q1.push_back(last1);
  endtask

  // Golden driver plus protocol model: a read is pending from its rd_en until its
  // beat is taken, and the beat may only be requested two cycles after the read.
  always @(negedge clk) begin
    if (!run_en) begin
      k = 0; pend = 0; since = 0; last_hs = 0; gold_valid = 1'b0;
      n_rd = 0; n_hs = 0; stalls = 0; prot_err = 0;
    end else begin
      if (last_hs) begin k++; pend = 0; n_hs++; end
      if (rd_en0) begin
        if (pend) prot_err++;
        pend = 1; since = 0; n_rd++;
      end else if (pend) begin
        since++;
      end
      exp_ready = pend && (since >= 2);
      if (gold_ready0 !== exp_ready || gold_ready1 !== exp_ready) prot_err++;
      gold_valid = stall_mode ? 1'($urandom_range(1)) : 1'b1;
      gold_data  = (k < NPIX) ? gld[k] : 32'h0;
      last_hs    = exp_ready && gold_valid;
      if (exp_ready && !gold_valid) stalls++;
    end
  end

  task automatic cmp_dut(input string t, input res_t e, input logic [15:0] cnt, input int cw,
                         input logic fev, input logic [1:0] fr, input logic [1:0] fc,
                         input logic [1:0] fh, input logic [7:0] mx, input logic dn);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s.err_cnt%0d", t, c), int'(cnt >> (c * cw)) & ((1 << cw) - 1), int'(e.cnt[c]));
    check({t, ".first_err_valid"}, int'(fev), int'(e.fev));
    check({t, ".first_err_row"}, int'(fr), int'(e.frow));
    check({t, ".first_err_col"}, int'(fc), int'(e.fcol));
    check({t, ".first_err_ch"}, int'(fh), int'(e.fch));
    check({t, ".max_abs_err"}, int'(mx), int'(e.mx));
    check({t, ".done"}, int'(dn), int'(e.done));
  endtask

  // Monitor: one cycle after busy falls the frame's results are final.
  initial begin
    bit b_prev;
    res_t e0, e1;
    b_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_prev && !busy0) begin
        @(negedge clk);
        if (q0.size() == 0 || q1.size() == 0) begin
          check("unexpected_frame_end", 1, 0);
        end else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          cmp_dut("tol0", e0, err_cnt0, 4, fev0, frow0, fcol0, fch0, mx0, done0);
          cmp_dut("tol5", e1, {4'b0, err_cnt1}, 3, fev1, frow1, fcol1, fch1, mx1, done1);
        end
      end
      b_prev = busy0;
    end
  end

  task automatic fill_same();
    for (int p = 0; p < NPIX; p++) begin mem[p] = $urandom; gld[p] = mem[p]; end
  endtask

  task automatic fill_rand();
    fill_same();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < 4; c++)
        if ($urandom_range(3) == 0)
          gld[p][8*c +: 8] = ($urandom_range(1) == 1) ? mem[p][8*c +: 8] + 8'($urandom_range(1, 10))
                                                      : mem[p][8*c +: 8] - 8'($urandom_range(1, 10));
  endtask

  task automatic launch(input logic [3:0] mask, input bit stall, output int e0);
    @(negedge clk);
    run_en = 1'b1; stall_mode = stall; ch_mask = mask; start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0; ch_mask = 4'($urandom);
  endtask

  task automatic run_frame(input logic [3:0] mask, input bit stall, input int start_at);
    int e0;
    bit got;
    push_exp(mask, NPIX, 1'b1);
    launch(mask, stall, e0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      if (done0) got = 1'b1;
      start = (start_at >= 0) && (k == start_at);
      if (start) ch_mask = 4'($urandom);
    end
    start = 1'b0;
    check("done_reached", int'(got), 1);
    if (got) check("done_latency", cyc - e0, 3 * NPIX + 1 + stalls);
    check("rd_en_pulses", n_rd, NPIX);
    check("gold_handshakes", n_hs, NPIX);
    check("gold_ready_protocol", prot_err, 0);
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pixel(input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (k == n) got = 1'b1;
    end
    check("pixel_reached", int'(got), 1);
  endtask

  task automatic abort_frame(input logic [3:0] mask, input bit with_start);
    int e0;
    push_exp(mask, 5, 1'b0);
    launch(mask, 1'b0, e0);
    wait_pixel(5);
    abort = 1'b1; start = with_start;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #1;
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    run_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_rd_en", int'(rd_en0), 0);
    check("rst_gold_ready", int'(gold_ready0), 0);
    check("rst_err_cnt0", int'(err_cnt0), 0);
    check("rst_err_cnt1", int'(err_cnt1), 0);
    check("rst_first_err", int'({fev0, frow0, fcol0, fch0}), 0);
    check("rst_max", int'(mx0), 0);
    check("rst_rd_addr", int'({rd_row0, rd_col0}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill_same();
    run_frame(4'hF, 1'b0, -1);

    fill_same();
    mem[6][23:16] = 8'($urandom_range(0, 200));
    gld[6][23:16] = mem[6][23:16] + 8'd5;
    run_frame(4'hF, 1'b0, -1);

    fill_same();
    gld[3][15:8]  = mem[3][15:8] ^ 8'h40;
    gld[8][7:0]   = mem[8][7:0] ^ 8'h10;
    mem[8][31:24] = 8'd0;
    gld[8][31:24] = 8'd255;
    run_frame(4'hF, 1'b0, -1);
    run_frame(4'b1101, 1'b0, -1);

    fill_same();
    for (int p = 0; p < NPIX; p++) gld[p][7:0] = mem[p][7:0] ^ 8'h80;
    run_frame(4'hF, 1'b0, -1);

    check("done_level_held", int'(done0), 1);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    check("done_abort_done", int'(done0), 0);
    check("done_abort_busy", int'(busy0), 0);
    check("done_abort_cnt", int'(err_cnt0), int'(pack0(last0)));
    check("done_abort_max", int'(mx0), int'(last0.mx));

    for (int i = 0; i < 4; i++) begin
      fill_rand();
      run_frame(4'($urandom_range(1, 15)), 1'b1, -1);
    end

    fill_rand();
    run_frame(4'hF, 1'b1, 3);

    fill_rand();
    abort_frame(4'hF, 1'b0);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    check("idle_both_busy", int'(busy0), 0);
    check("idle_both_cnt", int'(err_cnt0), int'(pack0(last0)));
    fill_rand();
    abort_frame(4'hB, 1'b1);

    fill_rand();
    for (int p = 0; p < 4; p++) gld[p][7:0] = mem[p][7:0] ^ 8'h20;
    q0.push_back('0);
    q1.push_back('0);
    launch(4'hF, 1'b0, e0);
    wait_pixel(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy0), 0);
    check("arst_err_cnt0", int'(err_cnt0), 0);
    check("arst_err_cnt1", int'(err_cnt1), 0);
    check("arst_first_err", int'({fev0, frow0, fcol0, fch0}), 0);
    check("arst_max", int'(mx0), 0);
    check("arst_gold_ready", int'(gold_ready0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_en = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
